// File: rtl/unary_pkg.sv
// Shared definitions for the unary adder front end: default sizes,
// feeder state encoding and a small elaboration-time helper.
package unary_pkg;

  localparam int UNARY_LEN   = 16;
  localparam int UNARY_DRAIN = 20;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_STREAM = 2'd1,
    FS_DRAIN  = 2'd2,
    FS_DONE   = 2'd3
  } feeder_state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/unary_operand_feeder_if.sv
// Operand handshake plus the unary-adder drive pins of the operand feeder.
// The feeder sits on the slave side; whoever supplies operands is the master.
interface unary_operand_feeder_if #(
  parameter int VW = 5
);

  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] a_val;
  logic [VW-1:0] b_val;
  logic          A;
  logic          B;
  logic          en;
  logic          read_or_write;
  logic          sat;
  logic          done;

  modport master (
    output in_valid, a_val, b_val,
    input  in_ready, A, B, en, read_or_write, sat, done
  );

  modport slave (
    input  in_valid, a_val, b_val,
    output in_ready, A, B, en, read_or_write, sat, done
  );

endinterface

// File: rtl/unary_thermo_gen.sv
// Thermometer bit for one stream position: leading ones (i < value) or,
// when trailing, the ones packed at the end of the LEN-bit window.
module unary_thermo_gen
  import unary_pkg::*;
#(
  parameter int LEN = UNARY_LEN,
  parameter int VW  = $clog2(LEN + 1),
  parameter int IW  = 5
) (
  input  logic [VW-1:0] i_value,
  input  logic [IW-1:0] i_index,
  input  logic          i_trailing,
  output logic          o_bit
);

  localparam int W = maxInt(VW, IW);

  logic [W:0] w_idx;
  logic [W:0] w_val;
  logic [W:0] w_thr;

  // value is already clipped to LEN upstream, so LEN - value cannot underflow
  assign w_idx = (W + 1)'(i_index);
  assign w_val = (W + 1)'(i_value);
  assign w_thr = (W + 1)'(LEN) - w_val;

  assign o_bit = i_trailing ? (w_idx >= w_thr) : (w_idx < w_val);

endmodule

// File: rtl/unary_operand_feeder.sv
// Serialises a binary operand pair into LEN-cycle thermometer streams and
// sequences the unary adder's accumulate/emit control, one job at a time.
module unary_operand_feeder
  import unary_pkg::*;
#(
  parameter int LEN     = UNARY_LEN,
  parameter int VW      = $clog2(LEN + 1),
  parameter int DRAIN   = UNARY_DRAIN,
  parameter int B_TRAIL = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  unary_operand_feeder_if.slave  bus
);

  localparam int CMAX = maxInt(LEN, DRAIN);
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  localparam logic [1:0] S_IDLE   = FS_IDLE;
  localparam logic [1:0] S_STREAM = FS_STREAM;
  localparam logic [1:0] S_DRAIN  = FS_DRAIN;
  localparam logic [1:0] S_DONE   = FS_DONE;

  logic [1:0]    r_state;
  logic [1:0]    w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic [VW-1:0] r_aQ;
  logic [VW-1:0] r_bQ;
  logic [VW-1:0] w_aNext;
  logic [VW-1:0] w_bNext;
  logic [VW-1:0] w_aClip;
  logic [VW-1:0] w_bClip;
  logic          w_accept;
  logic          w_satIn;
  logic          w_bitA;
  logic          w_bitB;

  logic r_inReady;
  logic r_A;
  logic r_B;
  logic r_en;
  logic r_row;
  logic r_sat;
  logic r_done;

  // r_inReady gates acceptance so nothing is taken on the first edge after reset
  assign w_accept = (r_state == S_IDLE) && r_inReady && bus.in_valid;
  assign w_aClip  = (bus.a_val > VW'(LEN)) ? VW'(LEN) : bus.a_val;
  assign w_bClip  = (bus.b_val > VW'(LEN)) ? VW'(LEN) : bus.b_val;
  assign w_satIn  = (bus.a_val > VW'(LEN)) || (bus.b_val > VW'(LEN));

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_aNext     = r_aQ;
    w_bNext     = r_bQ;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stateNext = S_STREAM;
          w_cntNext   = '0;
          w_aNext     = w_aClip;
          w_bNext     = w_bClip;
        end
      end
      S_STREAM: begin
        if (r_cnt == CW'(LEN - 1)) begin
          w_stateNext = S_DRAIN;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == CW'(DRAIN - 1)) begin
          w_stateNext = S_DONE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
        w_cntNext   = '0;
      end
      default: begin
        w_stateNext = S_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Stream bits are computed for the upcoming cycle so that bit 0 is
  // registered on the very edge that accepts the operands.
  unary_thermo_gen #(
    .LEN (LEN),
    .VW  (VW),
    .IW  (CW)
  ) u_thermoA (
    .i_value    (w_aNext),
    .i_index    (w_cntNext),
    .i_trailing (1'b0),
    .o_bit      (w_bitA)
  );

  unary_thermo_gen #(
    .LEN (LEN),
    .VW  (VW),
    .IW  (CW)
  ) u_thermoB (
    .i_value    (w_bNext),
    .i_index    (w_cntNext),
    .i_trailing (B_TRAIL != 0),
    .o_bit      (w_bitB)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_aQ      <= '0;
      r_bQ      <= '0;
      r_inReady <= 1'b0;
      r_A       <= 1'b0;
      r_B       <= 1'b0;
      r_en      <= 1'b0;
      r_row     <= 1'b0;
      r_sat     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_aQ      <= w_aNext;
      r_bQ      <= w_bNext;
      r_inReady <= (w_stateNext == S_IDLE);
      r_A       <= (w_stateNext == S_STREAM) && w_bitA;
      r_B       <= (w_stateNext == S_STREAM) && w_bitB;
      r_en      <= (w_stateNext == S_STREAM) || (w_stateNext == S_DRAIN);
      r_row     <= (w_stateNext == S_DRAIN);
      r_done    <= (w_stateNext == S_DONE);
      if (w_accept) begin
        r_sat <= w_satIn;
      end
    end
  end

  assign bus.in_ready      = r_inReady;
  assign bus.A             = r_A;
  assign bus.B             = r_B;
  assign bus.en            = r_en;
  assign bus.read_or_write = r_row;
  assign bus.sat           = r_sat;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_unary_operand_feeder.sv
// Random and directed jobs on two feeders (leading and trailing B) compared
// cycle by cycle against a position-based model of the job timeline.
module tb_unary_operand_feeder;
  import unary_pkg::*;

  localparam int LEN   = 16;
  localparam int DRAIN = 20;
  localparam int VW    = $clog2(LEN + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inValid;
  logic [VW-1:0] aVal;
  logic [VW-1:0] bVal;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  unary_operand_feeder_if #(.VW(VW)) bus0 ();
  unary_operand_feeder_if #(.VW(VW)) bus1 ();

  assign bus0.in_valid = inValid;
  assign bus0.a_val    = aVal;
  assign bus0.b_val    = bVal;
  assign bus1.in_valid = inValid;
  assign bus1.a_val    = aVal;
  assign bus1.b_val    = bVal;

  unary_operand_feeder #(.LEN(LEN), .VW(VW), .DRAIN(DRAIN), .B_TRAIL(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  unary_operand_feeder #(.LEN(LEN), .VW(VW), .DRAIN(DRAIN), .B_TRAIL(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] sampleBus(input int d);
    if (d == 0)
      return {bus0.A, bus0.B, bus0.en, bus0.read_or_write, bus0.done, bus0.in_ready, bus0.sat};
    return {bus1.A, bus1.B, bus1.en, bus1.read_or_write, bus1.done, bus1.in_ready, bus1.sat};
  endfunction

  // Cycle k counts from the accepting edge: k < LEN streams, then DRAIN
  // emit cycles, one done cycle, then idle with in_ready.
  task automatic checkCycle(input int k, input int aq, input int bq, input bit expSat);
    logic [6:0] obs;
    bit inStream;
    bit expB;
    for (int d = 0; d < 2; d++) begin
      obs      = sampleBus(d);
      inStream = (k < LEN);
      expB     = inStream && ((d == 1) ? (k >= LEN - bq) : (k < bq));
      checkOutput($sformatf("dut%0d.A k=%0d", d, k), obs[6], inStream && (k < aq));
      checkOutput($sformatf("dut%0d.B k=%0d", d, k), obs[5], expB);
      checkOutput($sformatf("dut%0d.en k=%0d", d, k), obs[4], k < LEN + DRAIN);
      checkOutput($sformatf("dut%0d.row k=%0d", d, k), obs[3], (k >= LEN) && (k < LEN + DRAIN));
      checkOutput($sformatf("dut%0d.done k=%0d", d, k), obs[2], k == LEN + DRAIN);
      checkOutput($sformatf("dut%0d.ready k=%0d", d, k), obs[1], k > LEN + DRAIN);
      checkOutput($sformatf("dut%0d.sat k=%0d", d, k), obs[0], expSat);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("%s dut%0d", tag, d), sampleBus(d), 0);
  endtask

  // Called on a negedge with both feeders idle; returns on the negedge where
  // in_ready is back, so a following call is accepted back-to-back.
  task automatic applyStimulus(input int a, input int b, input bit busyValid);
    int aq;
    int bq;
    bit expSat;
    int onesA;
    int onesB0;
    int onesB1;
    aq     = (a > LEN) ? LEN : a;
    bq     = (b > LEN) ? LEN : b;
    expSat = (a > LEN) || (b > LEN);
    onesA  = 0;
    onesB0 = 0;
    onesB1 = 0;
    checkOutput("readyBeforeAccept", {bus1.in_ready, bus0.in_ready}, 2'b11);
    inValid = 1'b1;
    aVal    = VW'(a);
    bVal    = VW'(b);
    for (int k = 0; k <= LEN + DRAIN + 1; k++) begin
      @(negedge clk);
      inValid = (k == LEN + DRAIN + 1) ? 1'b0 : busyValid;
      aVal    = VW'($urandom);
      bVal    = VW'($urandom);
      checkCycle(k, aq, bq, expSat);
      if (bus0.en && !bus0.read_or_write) begin
        onesA  += int'(bus0.A);
        onesB0 += int'(bus0.B);
        onesB1 += int'(bus1.B);
      end
    end
    checkOutput("onesA", onesA, aq);
    checkOutput("onesB lead", onesB0, bq);
    checkOutput("onesB trail", onesB1, bq);
    checkOutput("adderSum", onesA + onesB0, aq + bq);
  endtask

  task automatic idleCycles(input int n);
    inValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idleReady", {bus1.in_ready, bus0.in_ready}, 2'b11);
      checkOutput("idleEn", {bus1.en, bus0.en}, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    inValid = 1'b0;
    aVal    = '0;
    bVal    = '0;
    @(negedge clk);
    checkAllZero("inReset");
    inValid = 1'b1;
    @(negedge clk);
    checkAllZero("inResetValid");
    inValid = 1'b0;
    rst_n   = 1'b1;
    #1;
    checkOutput("readyAtRelease", {bus1.in_ready, bus0.in_ready}, 2'b00);
    @(negedge clk);
    checkOutput("readyAfterRelease", {bus1.in_ready, bus0.in_ready}, 2'b11);

    applyStimulus(5, 3, 1'b0);
    idleCycles(2);
    applyStimulus(3, 4, 1'b1);
    applyStimulus(0, 16, 1'b0);
    idleCycles(1);
    applyStimulus(20, 2, 1'b1);
    applyStimulus(7, 6, 1'b1);
    applyStimulus(16, 0, 1'b1);
    idleCycles(1);

    for (int j = 0; j < 8; j++) begin
      applyStimulus($urandom_range(0, (1 << VW) - 1), $urandom_range(0, (1 << VW) - 1),
                    1'($urandom));
      idleCycles($urandom_range(0, 2));
    end

    inValid = 1'b1;
    aVal    = VW'(9);
    bVal    = VW'(9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inValid = 1'b0;
    end
    checkOutput("midJobEn", {bus1.en, bus0.en}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midJobReset");
    @(negedge clk);
    checkAllZero("midJobResetHeld");
    rst_n = 1'b1;
    #1;
    checkOutput("readyAtRelease2", {bus1.in_ready, bus0.in_ready}, 2'b00);
    @(negedge clk);
    checkOutput("noDoneAfterReset", {bus1.done, bus0.done}, 2'b00);
    applyStimulus(11, 13, 1'b1);
    idleCycles(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
